// File: rtl/blk_b269e4.sv
// Polar-decoder f function (min-sum check node): c = sgn(a)*sgn(b)*min(|a|,|b|).
// Magnitudes saturate so the most negative code is never produced; one register stage.
module blk_b269e4 #(
  parameter int BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [BITS-1:0] a,
  input  logic signed [BITS-1:0] b,
  output logic signed [BITS-1:0] c
);

  localparam logic [BITS-2:0] MAX_MAG = {(BITS-1){1'b1}};

  logic [BITS-1:0] neg_a;
  logic [BITS-1:0] neg_b;
  logic [BITS-2:0] mag_a;
  logic [BITS-2:0] mag_b;
  logic [BITS-2:0] min_mag;
  logic            res_neg;
  logic [BITS-1:0] res_pos;
  logic [BITS-1:0] c_next;

  // Negating the most negative code overflows back to a set MSB; that case saturates.
  always_comb begin
    neg_a = '0 - a;
    neg_b = '0 - b;

    if (!a[BITS-1])          mag_a = a[BITS-2:0];
    else if (neg_a[BITS-1])  mag_a = MAX_MAG;
    else                     mag_a = neg_a[BITS-2:0];

    if (!b[BITS-1])          mag_b = b[BITS-2:0];
    else if (neg_b[BITS-1])  mag_b = MAX_MAG;
    else                     mag_b = neg_b[BITS-2:0];

    min_mag = (mag_a <= mag_b) ? mag_a : mag_b;
    res_neg = a[BITS-1] ^ b[BITS-1];
    res_pos = {1'b0, min_mag};

    // A zero magnitude stays zero regardless of sign.
    if (res_neg && (min_mag != '0)) c_next = '0 - res_pos;
    else                            c_next = res_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c <= '0;
    else        c <= c_next;
  end

endmodule

// File: tb/tb_blk_b269e4.sv
// Directed bench for blk_b269e4: reset, hand-computed vectors, exhaustive sweep.
module tb_blk_b269e4;

  logic              clk;
  logic              rst_n;
  logic signed [3:0] a;
  logic signed [3:0] b;
  logic signed [3:0] c;

  int n_tests;
  int n_fail;

  blk_b269e4 #(.BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [3:0] got,
                     input logic signed [3:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive a pair at the falling edge, then check c just after the next rising edge.
  task automatic apply(input int ai, input int bi, input int exp, input string tag);
    @(negedge clk);
    a = 4'(ai);
    b = 4'(bi);
    @(posedge clk);
    #1;
    chk(tag, c, 4'(exp));
  endtask

  function automatic int ref_f(input int ai, input int bi);
    int ma, mb, m;
    ma = (ai < 0) ? -ai : ai;
    mb = (bi < 0) ? -bi : bi;
    if (ma > 7) ma = 7;
    if (mb > 7) mb = 7;
    m = (ma < mb) ? ma : mb;
    if ((ai < 0) != (bi < 0)) return -m;
    return m;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a       = 4'($urandom_range(0, 15));
    b       = 4'($urandom_range(0, 15));
    #1;
    chk("reset_t0", c, 4'sd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk("reset_hold", c, 4'sd0);
    end
    @(negedge clk);
    a = 4'sd0;
    b = 4'sd0;
    rst_n = 1'b1;
    apply(0, 0, 0, "post_reset_0");
    apply(0, 0, 0, "post_reset_1");

    apply(5, 7, 5, "pulse_5_7");
    apply(0, 0, 0, "pulse_back_0");
    apply(5, -7, -5, "mixed_sign");
    apply(-5, -7, 5, "both_neg");
    apply(-8, 3, -3, "sat_a_min_b");
    apply(-8, -8, 7, "sat_both");
    apply(-8, 7, -7, "sat_eq_mag");
    apply(0, -6, 0, "zero_no_neg0");
    apply(-3, 3, -3, "equal_mag");
    apply(2, 4, 2, "b2b_0");
    apply(-1, 6, -1, "b2b_1");
    apply(7, -7, -7, "b2b_2");
    apply(0, 0, 0, "idle_zero");

    for (int i = 0; i < 256; i++) begin
      int ai, bi;
      ai = (i >> 4) - (((i >> 4) >= 8) ? 16 : 0);
      bi = (i & 15) - (((i & 15) >= 8) ? 16 : 0);
      apply(ai, bi, ref_f(ai, bi), "sweep");
      if (i == 200) begin
        // pair (-4,-8) leaves c = 4; reset must clear it without a clock edge
        chk("pre_async_rst", c, 4'sd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", c, 4'sd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
